// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack_lifo block.
// The optional sticky error flags are enabled with the STACK_LIFO_ERR_EN macro.
package stack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // Occupancy state of the stack; the empty/full flags are decoded from it.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

  // State that corresponds to a given occupancy. A jump straight from 0 to
  // depth (or back) lands in the end state without visiting ACTIVE.
  function automatic state_t state_for_count(input int unsigned cnt,
                                             input int unsigned depth);
    if (cnt == 0) begin
      return EMPTY;
    end
    if (cnt >= depth) begin
      return FULL;
    end
    return ACTIVE;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x DATA_W, one synchronous write port and one
// synchronous read port, no reset. A read and a write to the same address in
// one cycle returns the old contents.
module stack_ram
  import stack_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write and registered read; the read samples memory before this edge's write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_lifo.sv
// LIFO stack with registered pop data, EMPTY/ACTIVE/FULL occupancy FSM and,
// when STACK_LIFO_ERR_EN is defined, sticky overflow/underflow flags.
//
// Output strobe: dout_valid is high for exactly one cycle after the edge that
// accepted a pop (pop-only on a non-empty stack, or push+pop in any state);
// dout carries the popped word in that cycle and holds it until the next pop.
// There is no back-pressure: requests that cannot be served are dropped.
module stack_lifo
  import stack_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sm,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [PTR_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr,
  output state_t            dbg_state
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_t            r_state;
  logic [PTR_W-1:0]  r_count;
  logic              r_dout_zero;
  logic              r_dout_byp;
  logic [DATA_W-1:0] r_byp_data;
  logic              r_dout_valid;

  logic              w_req_push;
  logic              w_req_pop;
  logic              w_req_both;
  logic              w_is_empty;
  logic              w_is_full;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_do_swap;
  logic              w_do_bypass;
  logic              w_ovf_evt;
  logic              w_unf_evt;
  logic [ADDR_W-1:0] w_top_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [DATA_W-1:0] w_ram_q;
  logic [PTR_W-1:0]  w_count_nxt;

  // Request decode; nothing is requested while the block is deselected.
  assign w_req_push  = sm & push & ~pop;
  assign w_req_pop   = sm & pop & ~push;
  assign w_req_both  = sm & push & pop;
  assign w_is_empty  = (r_state == EMPTY);
  assign w_is_full   = (r_state == FULL);

  assign w_do_push   = w_req_push & ~w_is_full;
  assign w_do_pop    = w_req_pop & ~w_is_empty;
  assign w_do_swap   = w_req_both & ~w_is_empty;
  assign w_do_bypass = w_req_both & w_is_empty;
  assign w_ovf_evt   = w_req_push & w_is_full;
  assign w_unf_evt   = w_req_pop & w_is_empty;

  // Top-of-stack is entry count-1; at count=DEPTH the low bits wrap to 0 so
  // the subtraction still points at DEPTH-1.
  assign w_top_addr  = r_count[ADDR_W-1:0] - ADDR_W'(1);
  assign w_wr_addr   = w_do_push ? r_count[ADDR_W-1:0] : w_top_addr;
  // A write sampled while reset is held belongs to a discarded request.
  assign w_ram_we    = (w_do_push | w_do_swap) & rst_n;
  assign w_ram_re    = w_do_pop | w_do_swap;

  assign w_count_nxt = w_do_push ? (r_count + PTR_W'(1)) :
                       w_do_pop  ? (r_count - PTR_W'(1)) : r_count;

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_wr_addr),
    .i_wdata (din),
    .i_re    (w_ram_re),
    .i_raddr (w_top_addr),
    .o_rdata (w_ram_q)
  );

  // Occupancy FSM: state follows the occupancy the count moves to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_state <= state_for_count(32'(w_count_nxt), DEPTH);
    end
  end

  // Pop data path: selects zero after reset, the RAM read word after a pop or
  // swap, or the bypassed din after a push+pop on an empty stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_zero  <= 1'b1;
      r_dout_byp   <= 1'b0;
      r_byp_data   <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_do_pop | w_do_swap | w_do_bypass;
      if (w_do_pop | w_do_swap) begin
        r_dout_zero <= 1'b0;
        r_dout_byp  <= 1'b0;
      end else if (w_do_bypass) begin
        r_dout_zero <= 1'b0;
        r_dout_byp  <= 1'b1;
        r_byp_data  <= din;
      end
    end
  end

  assign dout       = r_dout_zero ? '0 : (r_dout_byp ? r_byp_data : w_ram_q);
  assign dout_valid = r_dout_valid;
  assign count      = r_count;
  assign empty      = w_is_empty;
  assign full       = w_is_full;
  assign dbg_state  = r_state;

`ifdef STACK_LIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a clear wins over a new error in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (err_clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end
      if (w_unf_evt) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err;
  assign w_unused_err = err_clr ^ w_ovf_evt ^ w_unf_evt;
  assign overflow     = 1'b0;
  assign underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_stack_lifo.sv
// Self-checking bench for stack_lifo: directed scenarios plus randomized
// traffic checked against a queue-based stack model.
module tb_stack_lifo;
  import stack_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = $clog2(DEPTH) + 1;
`ifdef STACK_LIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              rst_n;
  logic              sm;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] din;
  logic              err_clr;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [PTR_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;
  state_t            dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stack_lifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sm         (sm),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow),
    .err_clr    (err_clr),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_dout;
  bit                exp_valid;
  bit                exp_ovf;
  bit                exp_unf;
  int                n_cmp;
  int                n_err;

  task automatic model_reset();
    exp_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  // Applies one clock edge's worth of stack rules to the model.
  task automatic model_step();
    bit ovf_evt;
    bit unf_evt;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    exp_valid = 1'b0;
    if (sm) begin
      if (push && !pop) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(din);
        else ovf_evt = 1'b1;
      end else if (pop && !push) begin
        if (exp_q.size() > 0) begin
          exp_dout  = exp_q.pop_back();
          exp_valid = 1'b1;
        end else begin
          unf_evt = 1'b1;
        end
      end else if (push && pop) begin
        if (exp_q.size() > 0) begin
          exp_dout = exp_q[$];
          exp_q[exp_q.size()-1] = din;
        end else begin
          exp_dout = din;
        end
        exp_valid = 1'b1;
      end
    end
    if (ERR_EN) begin
      if (err_clr) begin
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
      end else begin
        exp_ovf = exp_ovf | ovf_evt;
        exp_unf = exp_unf | unf_evt;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    sm = 1'b0; push = 1'b0; pop = 1'b0; din = '0; err_clr = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic cycle(input bit s, input bit p, input bit q,
                       input logic [DATA_W-1:0] d, input bit c);
    sm = s; push = p; pop = q; din = d; err_clr = c;
    model_step();
    @(posedge clk);
    #1;
    sm = 1'b0; push = 1'b0; pop = 1'b0; din = '0; err_clr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    sm = 1'b0; push = 1'b0; pop = 1'b0; din = '0; err_clr = 1'b0;
    #2;
    n_cmp += 6;
    if (count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
    if (dout !== '0) begin n_err++; $display("FAIL reset_dout got=%h exp=00", dout); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
    apply_reset();
  endtask

  task automatic test_lifo_order();
    logic [DATA_W-1:0] seq [3];
    seq[0] = 8'h33; seq[1] = 8'h22; seq[2] = 8'h11;
    apply_reset();
    cycle(1, 1, 0, 8'h11, 0);
    cycle(1, 1, 0, 8'h22, 0);
    cycle(1, 1, 0, 8'h33, 0);
    n_cmp += 2;
    if (count !== PTR_W'(3)) begin n_err++; $display("FAIL order_count3 got=%0d exp=3", count); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL order_valid_pre got=%b exp=0", dout_valid); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 8'h00, 0);
      n_cmp += 2;
      if (dout !== seq[i]) begin n_err++; $display("FAIL order_pop%0d got=%h exp=%h", i, dout, seq[i]); end
      if (dout_valid !== 1'b1) begin n_err++; $display("FAIL order_valid%0d got=%b exp=1", i, dout_valid); end
    end
    cycle(0, 0, 0, 8'h00, 0);
    n_cmp += 4;
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL order_valid_post got=%b exp=0", dout_valid); end
    if (dout !== 8'h11) begin n_err++; $display("FAIL order_hold got=%h exp=11", dout); end
    if (count !== '0) begin n_err++; $display("FAIL order_count0 got=%0d exp=0", count); end
    if (empty !== 1'b1) begin n_err++; $display("FAIL order_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    apply_reset();
    cycle(1, 1, 0, 8'h77, 0);
    cycle(1, 0, 1, 8'h00, 0);
    cycle(1, 0, 1, 8'h00, 0);
    n_cmp += 3;
    if (underflow !== ERR_EN) begin n_err++; $display("FAIL unf_set got=%b exp=%b", underflow, ERR_EN); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL unf_valid got=%b exp=0", dout_valid); end
    if (dout !== 8'h77) begin n_err++; $display("FAIL unf_dout got=%h exp=77", dout); end
    cycle(0, 0, 0, 8'h00, 1);
    n_cmp++;
    if (underflow !== 1'b0) begin n_err++; $display("FAIL unf_clear got=%b exp=0", underflow); end
    // Clear and a new underflow on the same edge: the clear wins.
    cycle(1, 0, 1, 8'h00, 1);
    n_cmp++;
    if (underflow !== 1'b0) begin n_err++; $display("FAIL unf_clr_prio got=%b exp=0", underflow); end
  endtask

  task automatic test_full_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 1, 0, DATA_W'(i), 0);
      if (i == DEPTH - 2) begin
        n_cmp++;
        if (full !== 1'b0) begin n_err++; $display("FAIL full_early got=%b exp=0", full); end
      end
    end
    n_cmp += 3;
    if (full !== 1'b1) begin n_err++; $display("FAIL full_flag got=%b exp=1", full); end
    if (count !== PTR_W'(DEPTH)) begin n_err++; $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); end
    if (empty !== 1'b0) begin n_err++; $display("FAIL full_empty got=%b exp=0", empty); end
    cycle(1, 1, 0, 8'hAA, 0);
    n_cmp += 2;
    if (overflow !== ERR_EN) begin n_err++; $display("FAIL ovf_set got=%b exp=%b", overflow, ERR_EN); end
    if (count !== PTR_W'(DEPTH)) begin n_err++; $display("FAIL ovf_count got=%0d exp=%0d", count, DEPTH); end
    cycle(1, 0, 1, 8'h00, 0);
    n_cmp += 4;
    if (dout !== 8'h0F) begin n_err++; $display("FAIL ovf_pop got=%h exp=0f", dout); end
    if (dout_valid !== 1'b1) begin n_err++; $display("FAIL ovf_pop_valid got=%b exp=1", dout_valid); end
    if (full !== 1'b0) begin n_err++; $display("FAIL ovf_pop_full got=%b exp=0", full); end
    if (count !== PTR_W'(DEPTH - 1)) begin n_err++; $display("FAIL ovf_pop_count got=%0d exp=%0d", count, DEPTH - 1); end
  endtask

  task automatic test_swap();
    apply_reset();
    cycle(1, 1, 0, 8'h33, 0);
    cycle(1, 1, 0, 8'h44, 0);
    cycle(1, 1, 1, 8'h55, 0);
    n_cmp += 3;
    if (dout !== 8'h44) begin n_err++; $display("FAIL swap_dout got=%h exp=44", dout); end
    if (dout_valid !== 1'b1) begin n_err++; $display("FAIL swap_valid got=%b exp=1", dout_valid); end
    if (count !== PTR_W'(2)) begin n_err++; $display("FAIL swap_count got=%0d exp=2", count); end
    cycle(1, 0, 1, 8'h00, 0);
    n_cmp++;
    if (dout !== 8'h55) begin n_err++; $display("FAIL swap_pop1 got=%h exp=55", dout); end
    cycle(1, 0, 1, 8'h00, 0);
    n_cmp++;
    if (dout !== 8'h33) begin n_err++; $display("FAIL swap_pop2 got=%h exp=33", dout); end
  endtask

  task automatic test_bypass_and_select();
    apply_reset();
    cycle(1, 1, 1, 8'h66, 0);
    n_cmp += 4;
    if (dout !== 8'h66) begin n_err++; $display("FAIL byp_dout got=%h exp=66", dout); end
    if (dout_valid !== 1'b1) begin n_err++; $display("FAIL byp_valid got=%b exp=1", dout_valid); end
    if (count !== '0) begin n_err++; $display("FAIL byp_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin n_err++; $display("FAIL byp_empty got=%b exp=1", empty); end
    cycle(0, 1, 0, 8'h99, 0);
    n_cmp += 3;
    if (count !== '0) begin n_err++; $display("FAIL sm0_count got=%0d exp=0", count); end
    if (dout !== 8'h66) begin n_err++; $display("FAIL sm0_dout got=%h exp=66", dout); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL sm0_valid got=%b exp=0", dout_valid); end
    cycle(1, 1, 0, 8'h12, 0);
    cycle(0, 0, 1, 8'h00, 0);
    n_cmp += 2;
    if (count !== PTR_W'(1)) begin n_err++; $display("FAIL sm0_pop_count got=%0d exp=1", count); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL sm0_pop_valid got=%b exp=0", dout_valid); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, DATA_W'(i + 1), 0);
    cycle(1, 0, 1, 8'h00, 0);
    n_cmp += 2;
    if (count !== PTR_W'(5)) begin n_err++; $display("FAIL areset_pre_count got=%0d exp=5", count); end
    if (dout !== 8'h06) begin n_err++; $display("FAIL areset_pre_dout got=%h exp=06", dout); end
    sm = 1'b1; push = 1'b1; din = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (count !== '0) begin n_err++; $display("FAIL areset_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin n_err++; $display("FAIL areset_empty got=%b exp=1", empty); end
    if (dout !== '0) begin n_err++; $display("FAIL areset_dout got=%h exp=00", dout); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got=%b exp=0", dout_valid); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (count !== '0) begin n_err++; $display("FAIL areset_hold_count got=%0d exp=0", count); end
    sm = 1'b0; push = 1'b0; din = '0;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int push_pct;
    int pop_pct;
    apply_reset();
    for (int ph = 0; ph < 6; ph++) begin
      push_pct = (ph % 2 == 0) ? 85 : 20;
      pop_pct  = (ph % 2 == 0) ? 20 : 85;
      for (int n = 0; n < 70; n++) begin
        cycle($urandom_range(0, 9) != 0,
              $urandom_range(0, 99) < push_pct,
              $urandom_range(0, 99) < pop_pct,
              DATA_W'($urandom),
              $urandom_range(0, 19) == 0);
        n_cmp += 7;
        if (dout !== exp_dout) begin n_err++; $display("FAIL rnd_dout ph=%0d n=%0d got=%h exp=%h", ph, n, dout, exp_dout); end
        if (dout_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid ph=%0d n=%0d got=%b exp=%b", ph, n, dout_valid, exp_valid); end
        if (count !== PTR_W'(exp_q.size())) begin n_err++; $display("FAIL rnd_count ph=%0d n=%0d got=%0d exp=%0d", ph, n, count, exp_q.size()); end
        if (empty !== (exp_q.size() == 0)) begin n_err++; $display("FAIL rnd_empty ph=%0d n=%0d got=%b", ph, n, empty); end
        if (full !== (exp_q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full ph=%0d n=%0d got=%b", ph, n, full); end
        if (overflow !== exp_ovf) begin n_err++; $display("FAIL rnd_ovf ph=%0d n=%0d got=%b exp=%b", ph, n, overflow, exp_ovf); end
        if (underflow !== exp_unf) begin n_err++; $display("FAIL rnd_unf ph=%0d n=%0d got=%b exp=%b", ph, n, underflow, exp_unf); end
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    test_reset();
    test_lifo_order();
    test_underflow();
    test_full_overflow();
    test_swap();
    test_bypass_and_select();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
